// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the register-file geometry and the state encoding of the dump reader.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_A,
        SEND_B,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader.
// Drives both register-file read ports for one cycle per register pair, holds the
// pair, then streams {index, data} beats over a valid/ready interface.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   start, abort          begin a dump (IDLE only) / cancel a dump in progress
//   rd_addr1, rd_addr2    read addresses to the register file
//   rd_data1, rd_data2    combinational read data from the register file
//   out_valid, out_ready  beat handshake
//   out_index, out_data   current beat payload
//   busy, done            activity flag / one-cycle completion pulse
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_COUNT,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned DATA_W   = REG_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // Pointer value of the final pair; ptr is always even so ptr+1 never wraps.
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(NUM_REGS - 2);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [DATA_W-1:0] hold1_q, hold1_d;
    logic [DATA_W-1:0] hold2_q, hold2_d;
    logic [ADDR_W-1:0] ptr_p1;

    assign ptr_p1 = ptr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        hold1_d = hold1_q;
        hold2_d = hold2_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                end
            end
            FETCH: begin
                // Pair is snapshotted here; later register writes are not seen.
                hold1_d = rd_data1;
                hold2_d = rd_data2;
                addr1_d = ptr_q;
                addr2_d = ptr_p1;
                state_d = SEND_A;
            end
            SEND_A: begin
                if (out_ready) begin
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                if (out_ready) begin
                    if (ptr_q == LastPtr) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(2);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                ptr_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start in IDLE.
        if (abort) begin
            state_d = IDLE;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            hold1_q <= '0;
            hold2_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            hold1_q <= hold1_d;
            hold2_q <= hold2_d;
        end
    end

    // Outputs decode from registered state only, so out_ready never reaches out_valid.
    always_comb begin
        out_valid = 1'b0;
        out_index = '0;
        out_data  = '0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        rd_addr1  = addr1_q;
        rd_addr2  = addr2_q;

        case (state_q)
            FETCH: begin
                rd_addr1 = ptr_q;
                rd_addr2 = ptr_p1;
            end
            SEND_A: begin
                out_valid = 1'b1;
                out_index = ptr_q;
                out_data  = hold1_q;
            end
            SEND_B: begin
                out_valid = 1'b1;
                out_index = ptr_p1;
                out_data  = hold2_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader.
// A behavioural register file feeds the read ports; each dump is checked against a
// snapshot of that register file taken when the dump starts.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    localparam int NUM = 32;
    localparam int AW  = 5;
    localparam int DW  = 32;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rd_addr1, rd_addr2, out_index;
    logic [DW-1:0] rd_data1, rd_data2, out_data;
    logic          out_valid, busy, done;

    logic [DW-1:0] regs [NUM];

    int n_compared   = 0;
    int n_mismatched = 0;

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

    always #5 clock = ~clock;

    regfile_dump_reader #(
        .NUM_REGS (NUM),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    // abort_beat >= 0 stalls on that beat for a cycle, then aborts.
    // restart_at >= 0 pulses start in that cycle while busy.
    // coh_reg >= 0 overwrites that register once the beat before it is visible.
    // reset_cycle >= 0 asserts reset mid-cycle in that cycle.
    task automatic run_dump(input int ready_mode, input int abort_beat, input int restart_at,
                            input int coh_reg, input int reset_cycle,
                            output int n_beats, output int n_done,
                            output int done_cycle, output int idle_cycle);
        logic [DW-1:0] exp_data [NUM];
        int nb, last_hs, k;
        bit stalled, seen_abort, aborted, coh_done;
        for (int i = 0; i < NUM; i++) exp_data[i] = regs[i];
        nb = 0; last_hs = -10; k = 0;
        n_done = 0; done_cycle = -1; idle_cycle = -1; n_beats = 0;
        stalled = 0; seen_abort = 0; aborted = 0; coh_done = 0;

        @(negedge clock);
        start = 1'b1;
        out_ready = 1'b1;
        for (int cycle = 1; cycle <= 400; cycle++) begin
            @(negedge clock);
            start = (cycle == restart_at);
            abort = 1'b0;
            if (cycle == reset_cycle) begin
                reset = 1'b1;
                #1;
                check_eq("async_reset_outputs",
                         64'({out_valid, busy, done, out_index, out_data, rd_addr1, rd_addr2}),
                         64'(0));
                @(negedge clock);
                reset = 1'b0;
                start = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    check_eq("idle_after_reset", 64'({busy, out_valid, done}), 64'(0));
                end
                n_beats = nb;
                return;
            end
            if (aborted) begin
                check_eq("abort_valid_low", 64'(out_valid), 64'(0));
                check_eq("abort_busy_low", 64'(busy), 64'(0));
                check_eq("abort_no_done", 64'(done), 64'(0));
                idle_cycle = cycle;
                break;
            end
            if (cycle == 1) check_eq("fetch_after_start", 64'({busy, out_valid}), 64'(2'b10));
            if (stalled) check_eq("valid_held_in_stall", 64'(out_valid), 64'(1));
            if (out_valid) begin
                if (nb < NUM) begin
                    check_eq("beat_index", 64'(out_index), 64'(nb));
                    check_eq("beat_data", 64'(out_data), 64'(exp_data[nb]));
                end else begin
                    check_eq("extra_beat", 64'(out_valid), 64'(0));
                end
            end
            if (done) begin
                n_done++;
                done_cycle = cycle;
                check_eq("done_after_last_beat", 64'(cycle), 64'(last_hs + 1));
            end
            if (!busy && cycle > 1) begin
                idle_cycle = cycle;
                break;
            end

            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            if (abort_beat >= 0 && out_valid && int'(out_index) == abort_beat) begin
                out_ready = 1'b0;
                if (seen_abort) begin
                    abort   = 1'b1;
                    aborted = 1;
                end
                seen_abort = 1;
            end
            if (coh_reg > 0 && !coh_done && out_valid && int'(out_index) == coh_reg - 1) begin
                regs[coh_reg] = 32'hDEAD_BEEF;
                coh_done = 1;
            end
            stalled = out_valid && !out_ready && !aborted;
            if (out_valid && out_ready) begin
                if (nb == NUM - 1) last_hs = cycle;
                nb++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (idle_cycle < 0) check_eq("dump_timeout_busy", 64'(busy), 64'(0));
        n_beats = nb;
    endtask

    initial begin
        int nb, nd, dc, ic;
        for (int i = 0; i < NUM; i++) regs[i] = (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);

        repeat (2) @(negedge clock);
        check_eq("reset_outputs",
                 64'({out_valid, busy, done, out_index, out_data, rd_addr1, rd_addr2}), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("idle_without_start", 64'({busy, out_valid}), 64'(0));

        // Start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", 64'(busy), 64'(0));

        // Full dump, always ready.
        run_dump(0, -1, -1, -1, -1, nb, nd, dc, ic);
        check_eq("full_beats", 64'(nb), 64'(NUM));
        check_eq("full_done_count", 64'(nd), 64'(1));
        check_eq("full_done_cycle", 64'(dc), 64'(3 * NUM / 2 + 1));
        check_eq("full_idle_cycle", 64'(ic), 64'(3 * NUM / 2 + 2));

        // Backpressure 1,0,0.
        run_dump(1, -1, -1, -1, -1, nb, nd, dc, ic);
        check_eq("bp_beats", 64'(nb), 64'(NUM));
        check_eq("bp_done_count", 64'(nd), 64'(1));

        // Abort on stalled beat 9, then restart from index 0.
        run_dump(0, 9, -1, -1, -1, nb, nd, dc, ic);
        check_eq("abort_beats", 64'(nb), 64'(9));
        check_eq("abort_done_count", 64'(nd), 64'(0));
        run_dump(0, -1, -1, -1, -1, nb, nd, dc, ic);
        check_eq("restart_beats", 64'(nb), 64'(NUM));
        check_eq("restart_done_count", 64'(nd), 64'(1));

        // Write to reg 5 after its pair was fetched: old value, then new value next dump.
        run_dump(0, -1, -1, 5, -1, nb, nd, dc, ic);
        check_eq("coh_beats", 64'(nb), 64'(NUM));
        run_dump(0, -1, -1, -1, -1, nb, nd, dc, ic);
        check_eq("coh_new_beats", 64'(nb), 64'(NUM));

        // Start while busy is ignored.
        run_dump(0, -1, 10, -1, -1, nb, nd, dc, ic);
        check_eq("restart_busy_beats", 64'(nb), 64'(NUM));
        check_eq("restart_busy_done", 64'(nd), 64'(1));
        check_eq("restart_busy_done_cycle", 64'(dc), 64'(3 * NUM / 2 + 1));

        // Async reset mid-dump.
        run_dump(0, -1, -1, -1, 20, nb, nd, dc, ic);
        check_eq("reset_no_done", 64'(nd), 64'(0));

        // Random contents and random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i < NUM; i++) regs[i] = $urandom;
            regs[0] = 32'h0;
            run_dump(2, -1, -1, -1, -1, nb, nd, dc, ic);
            check_eq("rand_beats", 64'(nb), 64'(NUM));
            check_eq("rand_done_count", 64'(nd), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
